fcp_update_scheduler: RTL
=========================

Name: fcp_update_scheduler

Overview:
Generates FCP (flow-control) update messages for NUM_VC virtual channels and serialises them onto one 128-bit AXIS stream. That stream feeds the remote side's FCP sink, so it uses the same field packing. Each VC becomes pending on a local event pulse or on a periodic refresh sweep. The block picks pending VCs round-robin, fetches the VC's counters over a request/response stat port, and emits one AXIS beat per VC.

Parameters:
NUM_VC, 8, number of VCs scheduled (power of two, 2..64)
QUEUE_INDEX_WIDTH, 15, width of the VC field in the message and on the stat port
STAT_WIDTH, 32, width of fccl/qlen/fccr; fixed at 32 for the message format
AXIS_WIDTH, 128, output data width
REFRESH_CYCLES, 4096, refresh period in clk cycles; 0 disables periodic refresh
CNT_WIDTH, 32, width of the sent-message counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
evt_valid  in  1  event pulse: mark evt_vc pending
evt_vc  in  QUEUE_INDEX_WIDTH  VC for the event; values >= NUM_VC are ignored
stat_req_valid  out  1  single-cycle stat read request
stat_req_vc  out  QUEUE_INDEX_WIDTH  VC being read
stat_rsp_valid  in  1  stat response strobe
stat_rsp_fccl  in  STAT_WIDTH  flow-control credit limit
stat_rsp_qlen  in  STAT_WIDTH  queue length
stat_rsp_fccr  in  STAT_WIDTH  flow-control credits received
m_axis_fcp_tdata  out  AXIS_WIDTH  FCP message
m_axis_fcp_tvalid  out  1  message valid
m_axis_fcp_tready  in  1  downstream ready
pending  out  NUM_VC  pending bitmap, for debug
sent_count  out  CNT_WIDTH  messages accepted downstream; wraps

Behaviour:
- Reset: all outputs 0, pending cleared, FSM in IDLE, rr pointer = NUM_VC-1 (so VC0 wins first), refresh timer cleared. Reset mid-transfer drops tvalid the next cycle; the message is lost and is not retried.
- Pending bits:
  - set by evt_valid for a legal VC;
  - all set when the refresh timer reaches REFRESH_CYCLES-1; the timer then restarts at 0 and free-runs regardless of FSM state;
  - a bit clears in the cycle its VC is granted (REQ);
  - if a set and a clear hit the same bit in the same cycle, set wins, so that VC is sent again later.
- Arbitration: in IDLE with pending != 0, grant the first set bit searching from rr+1 upward with wrap-around. The grant is registered, then rr = granted VC. No pending bits → stay in IDLE.
- FSM:
  - IDLE → REQ on grant.
  - REQ (1 cycle): stat_req_valid=1, stat_req_vc=granted VC (zero-extended) → WAIT.
  - WAIT: on stat_rsp_valid, capture the three values → SEND. stat_rsp_valid in any other state is ignored. The stat port may respond in any latency ≥1 cycle and never drops a request.
  - SEND: tvalid=1 with tdata held stable until tready. On handshake: sent_count++ (mod 2^CNT_WIDTH), → IDLE. tvalid is never withdrawn without a handshake, except on reset.
- tdata packing:
  - [31:0]=fccl, [63:32]=qlen, [95:64]=fccr;
  - [96 +: QUEUE_INDEX_WIDTH]=VC;
  - all remaining upper bits 0.
- Throughput: at most one message per 4 cycles (IDLE, REQ, WAIT ≥1, SEND). Minimum latency from evt_valid to tvalid is 4 cycles with 1-cycle stat latency and the FSM idle.
- Events and refresh keep accumulating in pending during REQ/WAIT/SEND; nothing is ever dropped except on reset.

Test Plan:
- Reset, then evt VC3; stat responds 1 cycle later with fccl=0x100, qlen=0x20, fccr=0x80 → one beat with tdata=0x0003_00000080_00000020_00000100, tvalid first high 4 cycles after evt; sent_count=1; pending=0.
- Events VC5, VC1, VC6 in the same idle window → output order VC5, VC6, VC1 after a VC3 history (rr=3); then evt VC3 → VC3 served.
- tready held low 20 cycles during SEND → tvalid and tdata stable throughout; sent_count unchanged until the handshake; an evt VC2 arriving meanwhile is sent after.
- REFRESH_CYCLES=64, no events → every 64 cycles all 8 VCs are sent, once each, in order 0..7; a refresh firing during an in-flight sweep re-sends only already-cleared VCs.
- evt_valid for the granted VC in the REQ cycle → pending bit stays 1 and that VC is sent twice; evt_vc=9 with NUM_VC=8 → ignored.
- rst asserted during WAIT, then a late stat_rsp_valid → tvalid stays 0, pending=0, no beat emitted, sent_count=0.

Source files
------------

// File: rtl/fcp_update_scheduler.sv
// FCP update scheduler: picks pending VCs round-robin, reads their counters
// over the stat port and emits one AXIS beat per VC.
module fcp_update_scheduler #(
    parameter int NUM_VC            = 8,
    parameter int QUEUE_INDEX_WIDTH = 15,
    parameter int STAT_WIDTH        = 32,
    parameter int AXIS_WIDTH        = 128,
    parameter int REFRESH_CYCLES    = 4096,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         evt_valid,
    input  logic [QUEUE_INDEX_WIDTH-1:0] evt_vc,
    output logic                         stat_req_valid,
    output logic [QUEUE_INDEX_WIDTH-1:0] stat_req_vc,
    input  logic                         stat_rsp_valid,
    input  logic [STAT_WIDTH-1:0]        stat_rsp_fccl,
    input  logic [STAT_WIDTH-1:0]        stat_rsp_qlen,
    input  logic [STAT_WIDTH-1:0]        stat_rsp_fccr,
    output logic [AXIS_WIDTH-1:0]        m_axis_fcp_tdata,
    output logic                         m_axis_fcp_tvalid,
    input  logic                         m_axis_fcp_tready,
    output logic [NUM_VC-1:0]            pending,
    output logic [CNT_WIDTH-1:0]         sent_count
);

    localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        SEND
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [VW-1:0]                rr;
    logic [VW-1:0]                gnt;
    logic [VW-1:0]                sel;
    logic [VW-1:0]                idx;
    logic                         sel_ok;
    logic [NUM_VC-1:0]            set_mask;
    logic [NUM_VC-1:0]            clr_mask;
    logic [QUEUE_INDEX_WIDTH-1:0] vc_ext;
    logic [AXIS_WIDTH-1:0]        msg;
    logic                         refresh;

    generate
        if (REFRESH_CYCLES > 0) begin : g_refresh
            localparam int TW =
                (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
            logic [TW-1:0] timer;
            logic          wrap;

            assign wrap = (timer == TW'(REFRESH_CYCLES - 1));

            // Free-running: independent of the FSM
            always_ff @(posedge clk) begin
                if (rst) begin
                    timer <= '0;
                end else if (wrap) begin
                    timer <= '0;
                end else begin
                    timer <= timer + TW'(1);
                end
            end

            assign refresh = wrap;
        end else begin : g_no_refresh
            assign refresh = 1'b0;
        end
    endgenerate

    assign vc_ext = QUEUE_INDEX_WIDTH'(gnt);

    // Round-robin search starting just above the last grant
    always_comb begin
        sel    = rr;
        idx    = rr;
        sel_ok = 1'b0;
        for (int i = 1; i <= NUM_VC; i++) begin
            idx = rr + VW'(i);
            if (!sel_ok && pending[idx]) begin
                sel    = idx;
                sel_ok = 1'b1;
            end
        end
    end

    always_comb begin
        set_mask = {NUM_VC{refresh}};
        if (evt_valid && (evt_vc < QUEUE_INDEX_WIDTH'(NUM_VC))) begin
            set_mask[evt_vc[VW-1:0]] = 1'b1;
        end
        clr_mask = '0;
        if (state == REQ) begin
            clr_mask[gnt] = 1'b1;
        end
    end

    always_comb begin
        msg                          = '0;
        msg[0 +: STAT_WIDTH]         = stat_rsp_fccl;
        msg[32 +: STAT_WIDTH]        = stat_rsp_qlen;
        msg[64 +: STAT_WIDTH]        = stat_rsp_fccr;
        msg[96 +: QUEUE_INDEX_WIDTH] = vc_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        stat_req_valid    = 1'b0;
        m_axis_fcp_tvalid = 1'b0;
        unique case (state)
            IDLE: begin
                if (sel_ok) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                stat_req_valid = 1'b1;
                state_nxt      = WAIT;
            end
            WAIT: begin
                if (stat_rsp_valid) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                m_axis_fcp_tvalid = 1'b1;
                if (m_axis_fcp_tready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stat_req_vc = vc_ext;

    // A set in the same cycle as the grant clear wins
    always_ff @(posedge clk) begin
        if (rst) begin
            rr               <= VW'(NUM_VC - 1);
            gnt              <= '0;
            pending          <= '0;
            m_axis_fcp_tdata <= '0;
            sent_count       <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
            if (state == IDLE && sel_ok) begin
                gnt <= sel;
                rr  <= sel;
            end
            if (state == WAIT && stat_rsp_valid) begin
                m_axis_fcp_tdata <= msg;
            end
            if (state == SEND && m_axis_fcp_tready) begin
                sent_count <= sent_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
